dht11_poll_sched: RTL and testbench

Periodic acquisition scheduler for the `dht11` single-wire reader. It decides when a DHT11 transaction is started, supervises it with a timeout, and retries on checksum error or no response. It latches the last good humidity/temperature sample and reports status. It sits between the `dht11` reader (same `clk25M` domain) and the downstream consumers, such as display, UART and registers. The host can force an immediate read.

---
 rtl/dht11_poll_sched.sv | 212 +++++++++++++++++++++
 tb/tb_dht11_poll_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_poll_sched.sv
// dht11_poll_sched: periodic acquisition scheduler for the dht11 single-wire
// reader. It paces transactions, supervises each attempt with a timeout,
// retries on checksum error or silence, and latches the last good sample.
// All outputs are registered and the whole block runs in the clk25M domain.

module dht11_poll_sched #(
  parameter int unsigned POLL_CYCLES      = 50_000_000,  // idle cycles between polls, >= 2
  parameter int unsigned TIMEOUT_CYCLES   = 1_250_000,   // max cycles spent in WAIT
  parameter int unsigned RETRY_GAP_CYCLES = 25_000_000,  // cycles between failure and retry
  parameter int unsigned MAX_RETRY        = 3            // retries after the first attempt, 0..15
) (
  input  logic        clk25M,
  input  logic        rst,
  input  logic        req_now,
  output logic        rd_start,
  input  logic [31:0] rd_data,
  input  logic        rd_valid,
  input  logic        rd_err,
  output logic [7:0]  hum_int,
  output logic [7:0]  hum_dec,
  output logic [7:0]  temp_int,
  output logic [7:0]  temp_dec,
  output logic        sample_valid,
  output logic [7:0]  sample_seq,
  output logic        fail,
  output logic [7:0]  err_cnt,
  output logic        stale,
  output logic        busy
);

  // Counter widths hold the terminal value plus one, so the increment
  // taken on the cycle a counter is abandoned never wraps.
  localparam int PW = $clog2(POLL_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(RETRY_GAP_CYCLES + 1);

  localparam logic [PW-1:0] POLL_LAST    = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST     = GW'(RETRY_GAP_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [PW-1:0] pcnt;       // idle time since the last transaction ended
  logic [TW-1:0] tcnt;       // time spent waiting for the reader
  logic [GW-1:0] gcnt;       // time spent in the retry gap
  logic [3:0]    retry_cnt;  // retries already used in the current poll

  // Attempt outcome decode, shared by next-state and output logic.
  logic poll_due;
  logic timeout_hit;
  logic good_evt;
  logic bad_evt;
  logic retry_evt;
  logic fail_evt;

  // Registered-output D sides.
  logic start_d;
  logic busy_d;

  assign poll_due    = (pcnt == POLL_LAST);
  assign timeout_hit = (tcnt == TIMEOUT_LAST);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clk25M or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: rd_valid wins over rd_err and over the timeout.
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (req_now || poll_due) begin
          next_state = S_START;
        end
      end
      S_START: begin
        next_state = S_WAIT;
      end
      S_WAIT: begin
        if (rd_valid) begin
          next_state = S_IDLE;
        end else if (rd_err || timeout_hit) begin
          next_state = (retry_cnt < RETRY_LIMIT) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (gcnt == GAP_LAST) begin
          next_state = S_START;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Output decode: classify the WAIT cycle and form the registered-output inputs.
  always_comb begin
    good_evt  = 1'b0;
    bad_evt   = 1'b0;
    retry_evt = 1'b0;
    fail_evt  = 1'b0;
    start_d   = 1'b0;
    busy_d    = 1'b0;

    if (state == S_WAIT) begin
      good_evt = rd_valid;
      bad_evt  = !rd_valid && (rd_err || timeout_hit);
    end

    retry_evt = bad_evt && (retry_cnt < RETRY_LIMIT);
    fail_evt  = bad_evt && !retry_evt;

    // Registering these from next_state makes rd_start coincide with START
    // and busy track the state register exactly, with no extra latency.
    start_d = (next_state == S_START);
    busy_d  = (next_state != S_IDLE);
  end

  // Interval counters: each runs only while its state is held and restarts from 0.
  always_ff @(posedge clk25M or posedge rst) begin
    if (rst) begin
      pcnt      <= '0;
      tcnt      <= '0;
      gcnt      <= '0;
      retry_cnt <= '0;
    end else begin
      if ((state == S_IDLE) && (next_state == S_IDLE)) begin
        pcnt <= pcnt + PW'(1);
      end else begin
        pcnt <= '0;
      end

      if (state == S_WAIT) begin
        tcnt <= tcnt + TW'(1);
      end else begin
        tcnt <= '0;
      end

      if ((state == S_GAP) && (next_state == S_GAP)) begin
        gcnt <= gcnt + GW'(1);
      end else begin
        gcnt <= '0;
      end

      if (retry_evt) begin
        retry_cnt <= retry_cnt + 4'd1;
      end else if (good_evt || fail_evt) begin
        retry_cnt <= '0;
      end
    end
  end

  // Control pulses and busy flag.
  always_ff @(posedge clk25M or posedge rst) begin
    if (rst) begin
      rd_start     <= 1'b0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      fail         <= 1'b0;
    end else begin
      rd_start     <= start_d;
      busy         <= busy_d;
      sample_valid <= good_evt;
      fail         <= fail_evt;
    end
  end

  // Sample store and status: bytes only change on a good read, so a failed
  // poll leaves the old sample visible and only raises stale.
  always_ff @(posedge clk25M or posedge rst) begin
    if (rst) begin
      hum_int    <= 8'h00;
      hum_dec    <= 8'h00;
      temp_int   <= 8'h00;
      temp_dec   <= 8'h00;
      sample_seq <= 8'h00;
      err_cnt    <= 8'h00;
      stale      <= 1'b1;
    end else begin
      if (good_evt) begin
        {hum_int, hum_dec, temp_int, temp_dec} <= rd_data;
        sample_seq <= sample_seq + 8'd1;
        stale      <= 1'b0;
      end else if (fail_evt) begin
        stale <= 1'b1;
        if (err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dht11_poll_sched.sv
// Testbench for dht11_poll_sched. Directed stimulus pushes the expected
// rd_start / sample_valid / fail events (with cycle stamps) into a queue;
// a monitor on the falling edge pops and compares whenever the DUT pulses
// one of them. Cycle N is the value sampled at the N-th rising edge after
// reset release, which is what cnt reads at the falling edge before it.

`timescale 1ns/1ps

module tb_dht11_poll_sched;

  localparam int P = 100;
  localparam int T = 50;
  localparam int G = 20;
  localparam int R = 2;

  logic        clk25M  = 1'b0;
  logic        rst     = 1'b1;
  logic        req_now = 1'b0;
  logic        rd_valid = 1'b0;
  logic        rd_err  = 1'b0;
  logic [31:0] rd_data = '0;

  logic        rd_start;
  logic [7:0]  hum_int, hum_dec, temp_int, temp_dec;
  logic        sample_valid;
  logic [7:0]  sample_seq;
  logic        fail;
  logic [7:0]  err_cnt;
  logic        stale;
  logic        busy;

  dht11_poll_sched #(
    .POLL_CYCLES     (P),
    .TIMEOUT_CYCLES  (T),
    .RETRY_GAP_CYCLES(G),
    .MAX_RETRY       (R)
  ) dut (
    .clk25M      (clk25M),
    .rst         (rst),
    .req_now     (req_now),
    .rd_start    (rd_start),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_err      (rd_err),
    .hum_int     (hum_int),
    .hum_dec     (hum_dec),
    .temp_int    (temp_int),
    .temp_dec    (temp_dec),
    .sample_valid(sample_valid),
    .sample_seq  (sample_seq),
    .fail        (fail),
    .err_cnt     (err_cnt),
    .stale       (stale),
    .busy        (busy)
  );

  typedef enum int {EV_START = 0, EV_SAMPLE = 1, EV_FAIL = 2} ev_kind_t;

  typedef struct {
    ev_kind_t    kind;
    int          cyc;
    logic [31:0] data;
    int          seq;
    int          err;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] exp_data = '0;
  int          exp_seq  = 0;
  int          exp_err  = 0;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;

  ev_t      mon_e;
  ev_kind_t mon_k;

  always #20 clk25M = ~clk25M;

  // Cycle index since the last reset release.
  always @(posedge clk25M or posedge rst) begin
    if (rst) cnt <= 0;
    else     cnt <= cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cnt);
    end
  endtask

  function automatic void push_start(input int c);
    ev_t e;
    e.kind = EV_START; e.cyc = c; e.data = '0; e.seq = 0; e.err = 0;
    exp_q.push_back(e);
  endfunction

  function automatic void push_sample(input int c, input logic [31:0] d);
    ev_t e;
    exp_data = d;
    exp_seq  = (exp_seq + 1) % 256;
    e.kind = EV_SAMPLE; e.cyc = c; e.data = d; e.seq = exp_seq; e.err = exp_err;
    exp_q.push_back(e);
  endfunction

  function automatic void push_fail(input int c);
    ev_t e;
    exp_err = (exp_err == 255) ? 255 : exp_err + 1;
    e.kind = EV_FAIL; e.cyc = c; e.data = exp_data; e.seq = exp_seq; e.err = exp_err;
    exp_q.push_back(e);
  endfunction

  // Advance to the falling edge of cycle c (inputs set here are sampled in cycle c).
  task automatic goto(input int c);
    if (cnt > c) check("schedule_late", cnt, c);
    while (cnt < c) @(negedge clk25M);
  endtask

  task automatic pulse_valid(input int c, input logic [31:0] d, input logic with_err);
    goto(c);
    rd_valid = 1'b1; rd_err = with_err; rd_data = d;
    @(negedge clk25M);
    rd_valid = 1'b0; rd_err = 1'b0;
  endtask

  task automatic pulse_err(input int c);
    goto(c);
    rd_err = 1'b1;
    @(negedge clk25M);
    rd_err = 1'b0;
  endtask

  task automatic pulse_req(input int c);
    goto(c);
    req_now = 1'b1;
    @(negedge clk25M);
    req_now = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_start"}, rd_start, 0);
    check({tag, "_sample_valid"}, sample_valid, 0);
    check({tag, "_fail"}, fail, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_stale"}, stale, 1);
    check({tag, "_sample_seq"}, sample_seq, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_sample_bytes"}, {hum_int, hum_dec, temp_int, temp_dec}, 32'h0);
  endtask

  // Monitor: every output pulse must match the next queued expectation.
  always @(negedge clk25M) begin
    if (!rst && (rd_start || sample_valid || fail)) begin
      mon_k = rd_start ? EV_START : (sample_valid ? EV_SAMPLE : EV_FAIL);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", mon_k, cnt);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", mon_k, mon_e.kind);
        check("event_cycle", cnt, mon_e.cyc);
        if (mon_k == EV_SAMPLE && mon_e.kind == EV_SAMPLE) begin
          check("sample_bytes", {hum_int, hum_dec, temp_int, temp_dec}, mon_e.data);
          check("sample_seq", sample_seq, mon_e.seq);
          check("stale_after_good", stale, 0);
          check("busy_after_good", busy, 0);
          check("err_cnt_on_good", err_cnt, mon_e.err);
        end
        if (mon_k == EV_FAIL && mon_e.kind == EV_FAIL) begin
          check("bytes_held_on_fail", {hum_int, hum_dec, temp_int, temp_dec}, mon_e.data);
          check("stale_on_fail", stale, 1);
          check("err_cnt_on_fail", err_cnt, mon_e.err);
          check("busy_on_fail", busy, 0);
        end
      end
    end
  end

  // Run-time bound: a hang becomes a reported failure.
  initial begin
    #(40 * 40_000);
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cnt);
    $fatal(1);
  end

  initial begin
    int s;

    // Reset state.
    repeat (3) @(negedge clk25M);
    check_reset_values("reset");
    push_start(P);
    rst = 1'b0;

    // Nominal poll: rd_start at 100, reply 30 cycles later.
    push_sample(131, 32'h3500_1842);
    push_start(231);
    pulse_valid(130, 32'h3500_1842, 1'b0);
    goto(200);
    check("busy_in_idle", busy, 0);

    // Checksum retry: error at 236 -> retry start at 257, then good.
    push_start(257);
    pulse_err(236);
    goto(245);
    check("busy_in_gap", busy, 1);
    push_sample(261, 32'h3600_1905);
    push_start(361);
    pulse_valid(260, 32'h3600_1905, 1'b0);

    // Total failure: no response to three attempts, then polling resumes.
    push_start(432);
    push_start(503);
    push_fail(554);
    push_start(654);
    goto(560);
    check("stale_after_fail", stale, 1);

    // Forced read: IDLE from 661, req_now at IDLE cycle 10 -> start at 672.
    push_sample(661, 32'h2A05_1700);
    push_start(672);
    pulse_valid(660, 32'h2A05_1700, 1'b0);
    pulse_req(671);
    pulse_req(680);              // during WAIT: must not start anything
    push_sample(691, 32'h2B06_1801);
    push_start(791);
    pulse_valid(690, 32'h2B06_1801, 1'b0);

    // Simultaneous rd_valid + rd_err is a success.
    push_sample(801, 32'h1122_3344);
    push_start(901);
    pulse_valid(800, 32'h1122_3344, 1'b1);

    // rd_valid / rd_err while IDLE are ignored.
    pulse_valid(830, 32'hDEAD_BEEF, 1'b0);
    pulse_err(835);
    goto(840);
    check("bytes_after_idle_valid", {hum_int, hum_dec, temp_int, temp_dec}, 32'h1122_3344);
    check("seq_after_idle_valid", sample_seq, 5);
    check("err_cnt_after_idle_err", err_cnt, 1);

    // rd_valid on the timeout cycle (901 + 50) is a success.
    push_sample(952, 32'h5566_7788);
    push_start(1052);
    pulse_valid(951, 32'h5566_7788, 1'b0);

    // Fast good polls until sample_seq wraps to 0 (256 good samples total).
    s = 1052;
    for (int i = 0; i < 250; i++) begin
      push_sample(s + 2, {8'(i), 8'h5A, 8'(255 - i), 8'hC3});
      push_start(s + 3);
      pulse_valid(s + 1, {8'(i), 8'h5A, 8'(255 - i), 8'hC3}, 1'b0);
      pulse_req(s + 2);
      s = s + 3;
    end
    goto(s);
    check("sample_seq_wrapped", sample_seq, 0);

    // 300 failed polls (three rd_err each) saturate err_cnt at 255.
    for (int i = 0; i < 300; i++) begin
      push_start(s + 22);
      pulse_err(s + 1);
      push_start(s + 44);
      pulse_err(s + 23);
      push_fail(s + 46);
      push_start(s + 47);
      pulse_err(s + 45);
      pulse_req(s + 46);
      s = s + 47;
    end
    goto(s);
    check("err_cnt_saturated", err_cnt, 255);
    check("stale_after_many_fails", stale, 1);

    // Reset mid-WAIT restores reset values; next start 100 cycles after release.
    goto(s + 5);
    check("busy_mid_wait", busy, 1);
    rst = 1'b1;
    @(negedge clk25M);
    check_reset_values("mid_wait_reset");
    @(negedge clk25M);
    push_start(P);
    rst = 1'b0;
    goto(P + 10);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
